fp_to_int_seq: RTL
==================

Name: fp_to_int_seq

Overview:
Sequential converter from the team's 13-bit floating-point format (sign, 4-bit exp, 8-bit frac) to an 8-bit two's-complement integer. The fraction is read as 0.frac, so value = frac × 2^(exp−8).
The magnitude is right-shifted one bit per clock, then the sign is applied and the result saturated. The block is the reverse path of the int-to-fp/adder datapath. It sits between fp arithmetic units and integer consumers such as displays or counters. It uses a start/ready/done handshake.

Parameters:
FRAC_W, 8, fraction width; also the integer output width and the exponent bias.
EXP_W, 4, exponent width (unsigned exponent).

Ports:
clk  input  1  system clock; all logic is on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request conversion; sampled only while ready=1
sign  input  1  sign of the operand (1 = negative)
exp  input  EXP_W  unsigned exponent
frac  input  FRAC_W  fraction 0.frac; normally MSB=1, but unnormalized values are accepted
ready  output  1  high in IDLE; the block can accept start
done_tick  output  1  one-cycle pulse; int_out/ovf/udf are valid from this cycle
int_out  output  FRAC_W  two's-complement result; held until the next done_tick
ovf  output  1  result was saturated; held with int_out
udf  output  1  nonzero input truncated to 0; held with int_out

Behaviour:
- Reset (synchronous): state=IDLE, ready=1, done_tick=0, int_out=0, ovf=0, udf=0, internal mag/cnt=0.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch sign, exp, frac into internal registers; mag←frac; cnt←(exp≥8) ? 0 : 8−exp; go to SHIFT.
  - start=0 keeps the block in IDLE.
- SHIFT:
  - ready=0.
  - If cnt≠0: mag←mag>>1 (logical), cnt←cnt−1, stay in SHIFT.
  - If cnt=0: register the result (rules below) into int_out/ovf/udf, go to DONE.
- DONE: done_tick=1 for exactly one cycle, ready=0; go to IDLE.
- Latency:
  - With the start-sampling cycle as cycle 0, n = shift count, done_tick is high in cycle n+2.
  - exp≥8 gives cycle 2; exp=0 gives cycle 10.
  - ready returns to 1 in cycle n+3.
- Result rules, evaluated in this priority order on the latched operand:
  1. frac=0: int_out=0, ovf=0, udf=0, for any exp or sign.
  2. exp>8: ovf=1; int_out=0x7F if sign=0, 0x80 if sign=1.
  3. mag>127 (only possible at exp=8):
     - sign=1 and mag=128: int_out=0x80 (−128), ovf=0.
     - otherwise: ovf=1, saturate as in rule 2.
  4. mag=0 (frac≠0, bits shifted out): int_out=0, udf=1, ovf=0. This never produces −0.
  5. Otherwise: int_out = sign ? (−mag mod 256) : mag; flags 0.
- Truncation is toward zero; there is no rounding.
- start while ready=0 is ignored; it is not queued.
- Input changes after the start cycle do not affect the conversion in progress.
- reset mid-conversion:
  - Abort; next cycle state=IDLE, ready=1.
  - No done_tick is issued and the outputs are cleared.
- reset and start in the same cycle: reset wins; start is dropped.
- Back-to-back conversions: start may be asserted in the first cycle ready=1 after DONE.
- int_out/ovf/udf change only in the cycle that enters DONE (or on reset).

Test Plan:
1. sign=0, exp=4, frac=0xB0, start at cycle 0 → done_tick at cycle 6; int_out=0x0B, ovf=0, udf=0; ready=1 at cycle 7.
2. sign=1, exp=3, frac=0xE0 → done at cycle 7; int_out=0xF9 (−7), flags 0.
3. Boundaries:
   - sign=1, exp=8, frac=0x80 → done at cycle 2; int_out=0x80, ovf=0.
   - sign=0, exp=8, frac=0x80 → int_out=0x7F, ovf=1.
   - sign=1, exp=9, frac=0xFF → int_out=0x80, ovf=1, done at cycle 2.
4. Underflow and zero:
   - exp=0, frac=0xC0 → done at cycle 10; int_out=0, udf=1.
   - sign=1, exp=5, frac=0x00 → int_out=0x00, no flags, done at cycle 5.
5. Handshake:
   - Pulse start again at cycles 2 and 4 during test 1 → ignored; exactly one done_tick at cycle 6 with 0x0B.
   - Then start in the first ready cycle (7) with sign=0, exp=7, frac=0x80 → done_tick at cycle 10 (3 cycles after that start); int_out=0x40.
6. Reset: start (exp=0, frac=0xFF), assert reset at cycle 4 → ready=1 and int_out=0 in cycle 5; no done_tick in cycles 5–12.

Source files
------------

// File: rtl/fp_to_int_seq.sv
// Sequential float-to-integer converter: the magnitude is shifted right one bit
// per clock, then the sign is applied and the result saturated to FRAC_W bits.
`timescale 1ns/1ps
module fp_to_int_seq #(
    parameter int FRAC_W = 8,
    parameter int EXP_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              sign,
    input  logic [EXP_W-1:0]  exp,
    input  logic [FRAC_W-1:0] frac,
    output logic              ready,
    output logic              done_tick,
    output logic [FRAC_W-1:0] int_out,
    output logic              ovf,
    output logic              udf
);

    localparam int                CNT_W   = $clog2(FRAC_W + 1);
    localparam logic [EXP_W-1:0]  BIAS    = EXP_W'(FRAC_W);
    localparam logic [FRAC_W-1:0] SAT_POS = {1'b0, {(FRAC_W-1){1'b1}}};
    localparam logic [FRAC_W-1:0] SAT_NEG = {1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t            r_state, w_state_next;
    logic              r_sign, w_sign_next;
    logic [EXP_W-1:0]  r_exp, w_exp_next;
    logic [FRAC_W-1:0] r_frac, w_frac_next;
    logic [FRAC_W-1:0] r_mag, w_mag_next;
    logic [CNT_W-1:0]  r_cnt, w_cnt_next;
    logic [FRAC_W-1:0] r_int, w_int_next;
    logic              r_ovf, w_ovf_next;
    logic              r_udf, w_udf_next;

    logic [EXP_W-1:0]  w_shift;
    logic [FRAC_W-1:0] w_res;
    logic              w_res_ovf;
    logic              w_res_udf;

    assign w_shift = BIAS - exp;

    // Result rules in priority order, applied to the fully shifted magnitude.
    always_comb begin
        w_res     = '0;
        w_res_ovf = 1'b0;
        w_res_udf = 1'b0;
        if (r_frac == '0) begin
            w_res = '0;
        end else if (r_exp > BIAS) begin
            w_res_ovf = 1'b1;
            w_res     = r_sign ? SAT_NEG : SAT_POS;
        end else if (r_mag[FRAC_W-1]) begin
            if (r_sign && (r_mag == SAT_NEG)) begin
                w_res = SAT_NEG;
            end else begin
                w_res_ovf = 1'b1;
                w_res     = r_sign ? SAT_NEG : SAT_POS;
            end
        end else if (r_mag == '0) begin
            w_res_udf = 1'b1;
        end else begin
            w_res = r_sign ? -r_mag : r_mag;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sign_next  = r_sign;
        w_exp_next   = r_exp;
        w_frac_next  = r_frac;
        w_mag_next   = r_mag;
        w_cnt_next   = r_cnt;
        w_int_next   = r_int;
        w_ovf_next   = r_ovf;
        w_udf_next   = r_udf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sign_next  = sign;
                    w_exp_next   = exp;
                    w_frac_next  = frac;
                    w_mag_next   = frac;
                    w_cnt_next   = (exp >= BIAS) ? '0 : CNT_W'(w_shift);
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_cnt != '0) begin
                    w_mag_next = r_mag >> 1;
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_int_next   = w_res;
                    w_ovf_next   = w_res_ovf;
                    w_udf_next   = w_res_udf;
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_sign  <= 1'b0;
            r_exp   <= '0;
            r_frac  <= '0;
            r_mag   <= '0;
            r_cnt   <= '0;
            r_int   <= '0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_sign  <= w_sign_next;
            r_exp   <= w_exp_next;
            r_frac  <= w_frac_next;
            r_mag   <= w_mag_next;
            r_cnt   <= w_cnt_next;
            r_int   <= w_int_next;
            r_ovf   <= w_ovf_next;
            r_udf   <= w_udf_next;
        end
    end

    assign ready     = (r_state == S_IDLE);
    assign done_tick = (r_state == S_DONE);
    assign int_out   = r_int;
    assign ovf       = r_ovf;
    assign udf       = r_udf;

endmodule
